// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: parity mode encodings and the parity rule.
// The transmitter and the receiver both use them.
package uart_rx_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    // Parity bit that goes with a word whose XOR-reduction is data_xor.
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        return mode[0] ^ data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-symbol sampling of the serial line, parity and stop-bit checks,
// and one parallel word per frame with a single-cycle valid strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int         SYSCLK_FREQUENCY_HZ = 100_000_000,
    parameter int         BAUDRATE            = 1_000_000,
    parameter int         DATA_LENGTH         = 8,
    parameter bit         DOUBLE_STOPBIT      = 1'b0,
    parameter logic [1:0] PARITY              = PARITY_NONE
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   serial,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   valid,
    output logic                   parity_err,
    output logic                   frame_err
);

    localparam int CPS   = SYSCLK_FREQUENCY_HZ / BAUDRATE;
    localparam int CNT_W = $clog2(CPS);
    localparam int IDX_W = $clog2(DATA_LENGTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LENGTH - 1);
    localparam bit               HAS_PAR  = (PARITY != PARITY_NONE);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    state_t                 state, state_next;
    logic                   rx;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [DATA_LENGTH-1:0] shift;
    logic                   perr, ferr, stop2;
    logic                   cnt_clr, frame_start, smp_data, smp_par, smp_stop, done;
    logic                   bit_end;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (sysclk),
        .rst_n (rst_n),
        .d     (serial),
        .q     (rx)
    );

    assign bit_end = (cnt == CNT_LAST);

    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        frame_start = 1'b0;
        smp_data    = 1'b0;
        smp_par     = 1'b0;
        smp_stop    = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx) begin
                    frame_start = 1'b1;
                    cnt_clr     = 1'b1;
                    state_next  = ST_START;
                end
            end
            // A start bit that is high again at its midpoint was only a glitch.
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clr    = 1'b1;
                    state_next = rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_clr  = 1'b1;
                    smp_data = 1'b1;
                    if (idx == IDX_LAST)
                        state_next = HAS_PAR ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_clr    = 1'b1;
                    smp_par    = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_clr  = 1'b1;
                    smp_stop = 1'b1;
                    if (!(DOUBLE_STOPBIT && !stop2)) begin
                        done       = 1'b1;
                        state_next = rx ? ST_IDLE : ST_BREAK;
                    end
                end
            end
            // A line still low after the frame must go high before a new start counts.
            ST_BREAK: begin
                if (rx)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            stop2      <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_next;
            valid <= 1'b0;
            cnt   <= (cnt_clr || state == ST_IDLE) ? '0 : cnt + CNT_W'(1);
            if (frame_start) begin
                idx   <= '0;
                perr  <= 1'b0;
                ferr  <= 1'b0;
                stop2 <= 1'b0;
            end
            // LSB arrives first, so shifting in from the top leaves it in bit 0.
            if (smp_data) begin
                shift <= {rx, shift[DATA_LENGTH-1:1]};
                idx   <= idx + IDX_W'(1);
            end
            if (smp_par)
                perr <= rx ^ parity_bit(PARITY, ^shift);
            if (smp_stop) begin
                ferr  <= ferr | ~rx;
                stop2 <= 1'b1;
            end
            if (done) begin
                valid      <= 1'b1;
                data       <= shift;
                parity_err <= perr;
                frame_err  <= ferr | ~rx;
            end
        end
    end

endmodule
